// File: rtl/ks16_pkg.sv
// Shared types for the koggestone16 share scheduler: datapath width and FSM states.
package ks16_pkg;

   localparam int KS_W = 16;

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

endpackage

// File: rtl/ks16_share_sched_if.sv
// Requester/consumer bus of the shared adder; requester words are packed per index.
interface ks16_share_sched_if #(
   parameter int NREQ     = 4,
   parameter int MAXBEATS = 4,
   parameter int IDW      = 2
);
   localparam int BW = (MAXBEATS > 1) ? $clog2(MAXBEATS) : 1;

   logic [NREQ-1:0]        req_valid;
   logic [NREQ-1:0]        req_ready;
   logic [NREQ-1:0][15:0]  req_a;
   logic [NREQ-1:0][15:0]  req_b;
   logic [NREQ-1:0]        req_ci;
   logic [NREQ-1:0]        req_last;
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [15:0]            rsp_sum;
   logic                   rsp_co;
   logic [IDW-1:0]         rsp_id;
   logic [BW-1:0]          rsp_beat;
   logic                   rsp_last;
   logic                   err_trunc;

   modport master (
      output req_valid, req_a, req_b, req_ci, req_last, rsp_ready,
      input  req_ready, rsp_valid, rsp_sum, rsp_co, rsp_id, rsp_beat, rsp_last, err_trunc
   );

   modport slave (
      input  req_valid, req_a, req_b, req_ci, req_last, rsp_ready,
      output req_ready, rsp_valid, rsp_sum, rsp_co, rsp_id, rsp_beat, rsp_last, err_trunc
   );
endinterface

// File: rtl/koggestone16.sv
// 16-bit Kogge-Stone parallel-prefix adder with carry-in, purely combinational.
module koggestone16
   import ks16_pkg::*;
(
   input  logic [KS_W-1:0] a,
   input  logic [KS_W-1:0] b,
   input  logic            cin,
   output logic [KS_W-1:0] sum,
   output logic            co
);
   logic [KS_W-1:0] gg, pp, ng, np, mask, c;

   always_comb begin
      gg   = a & b;
      pp   = a ^ b;
      ng   = '0;
      np   = '0;
      mask = '0;
      // log2(16) prefix levels; low bits below the span keep their own propagate
      for (int l = 0; l < 4; l++) begin
         mask = (KS_W'(1) << (1 << l)) - KS_W'(1);
         ng   = gg | (pp & (gg << (1 << l)));
         np   = pp & ((pp << (1 << l)) | mask);
         gg   = ng;
         pp   = np;
      end
      c   = {gg[KS_W-2:0] | (pp[KS_W-2:0] & {(KS_W-1){cin}}), cin};
      sum = a ^ b ^ c;
      co  = gg[KS_W-1] | (pp[KS_W-1] & cin);
   end
endmodule

// File: rtl/ks16_rr_pick.sv
// Round-robin first-one finder: first set request at or above ptr, wrapping.
module ks16_rr_pick #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          any
);
   always_comb begin
      int j;
      j   = 0;
      gnt = '0;
      idx = '0;
      any = 1'b0;
      for (int k = 0; k < N; k++) begin
         j = (int'(ptr) + k) % N;
         if (!any && req[j]) begin
            any    = 1'b1;
            gnt[j] = 1'b1;
            idx    = IW'(j);
         end
      end
   end
endmodule

// File: rtl/ks16_share_sched.sv
// Round-robin share of one koggestone16 adder; grant is locked per packet and the
// carry chains across beats so narrow words build 32/48/64-bit sums.
module ks16_share_sched
   import ks16_pkg::*;
#(
   parameter int NREQ     = 4,
   parameter int MAXBEATS = 4,
   parameter int IDW      = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   ks16_share_sched_if.slave  bus
);
   localparam int BW = (MAXBEATS > 1) ? $clog2(MAXBEATS) : 1;

   typedef struct packed {
      logic [KS_W-1:0] sum;
      logic            co;
      logic [IDW-1:0]  id;
      logic [BW-1:0]   beat;
      logic            last;
   } rsp_t;

   state_e          state, state_nx;
   logic [IDW-1:0]  owner, rr_ptr, pick_idx, gidx;
   logic [NREQ-1:0] pick_gnt, gnt_vec;
   logic            pick_any;
   logic [BW-1:0]   beat;
   logic            carry, rsp_vld, err;
   rsp_t            rsp_q;

   logic            can_load, accept, at_max, pkt_end, forced, cin, co;
   logic [KS_W-1:0] sum;

   ks16_rr_pick #(.N(NREQ), .IW(IDW)) u_pick (
      .req (bus.req_valid),
      .ptr (rr_ptr),
      .gnt (pick_gnt),
      .idx (pick_idx),
      .any (pick_any)
   );

   assign gidx     = (state == BUSY) ? owner : pick_idx;
   assign gnt_vec  = (state == BUSY) ? ({{(NREQ-1){1'b0}}, 1'b1} << owner) : pick_gnt;
   assign can_load = !rsp_vld || bus.rsp_ready;
   // rst_n gating keeps req_ready low while reset is held, even with valid requests
   assign accept   = rst_n && can_load && |(bus.req_valid & gnt_vec);
   assign at_max   = (beat == BW'(MAXBEATS-1));
   assign pkt_end  = bus.req_last[gidx] || at_max;
   assign forced   = at_max && !bus.req_last[gidx];
   assign cin      = (beat == '0) ? bus.req_ci[gidx] : carry;

   koggestone16 u_add (
      .a   (bus.req_a[gidx]),
      .b   (bus.req_b[gidx]),
      .cin (cin),
      .sum (sum),
      .co  (co)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx      = state;
      bus.req_ready = '0;
      if (accept) begin
         state_nx      = pkt_end ? IDLE : BUSY;
         bus.req_ready = gnt_vec;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner   <= '0;
         rr_ptr  <= '0;
         beat    <= '0;
         carry   <= 1'b0;
         rsp_vld <= 1'b0;
         err     <= 1'b0;
         rsp_q   <= '0;
      end else if (accept) begin
         owner   <= gidx;
         carry   <= co;
         beat    <= pkt_end ? '0 : beat + 1'b1;
         rsp_vld <= 1'b1;
         rsp_q   <= '{sum: sum, co: co, id: gidx, beat: beat, last: pkt_end};
         if (pkt_end) rr_ptr <= (gidx == IDW'(NREQ-1)) ? '0 : gidx + 1'b1;
         if (forced)  err    <= 1'b1;
      end else if (bus.rsp_ready) begin
         rsp_vld <= 1'b0;
      end
   end

   assign bus.rsp_valid = rsp_vld;
   assign bus.rsp_sum   = rsp_q.sum;
   assign bus.rsp_co    = rsp_q.co;
   assign bus.rsp_id    = rsp_q.id;
   assign bus.rsp_beat  = rsp_q.beat;
   assign bus.rsp_last  = rsp_q.last;
   assign bus.err_trunc = err;
endmodule

// File: tb/tb_ks16_share_sched.sv
// Bench for ks16_share_sched: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a packet-level reference model.
module tb_ks16_share_sched;
   localparam int NREQ = 4, MAXB = 4, IDW = 2;

   logic clk = 1'b0;
   logic rst_n;
   int   total = 0, bad = 0;

   always #5 clk = ~clk;

   ks16_share_sched_if #(.NREQ(NREQ), .MAXBEATS(MAXB), .IDW(IDW)) bus ();
   ks16_share_sched #(.NREQ(NREQ), .MAXBEATS(MAXB), .IDW(IDW)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model: one packet owner, rr pointer, chained carry
   int m_owner, m_ptr, m_beat, m_carry, m_rv, m_err;
   int m_sum, m_co, m_id, m_bt, m_last;

   always @(negedge clk) begin
      int g, s, cin, fin, idx;
      logic [NREQ-1:0] er;
      if (!rst_n) begin
         m_owner = -1; m_ptr = 0; m_beat = 0; m_carry = 0; m_rv = 0; m_err = 0;
         chk("rst_valid", bus.rsp_valid, 0);
         chk("rst_ready", bus.req_ready, 0);
         chk("rst_err",   bus.err_trunc, 0);
         chk("rst_sum",   bus.rsp_sum,   0);
      end else begin
         g = -1;
         if (m_owner >= 0) g = m_owner;
         else for (int k = 0; k < NREQ; k++) begin
            idx = (m_ptr + k) % NREQ;
            if (g < 0 && bus.req_valid[idx]) g = idx;
         end
         er = '0;
         if (g >= 0 && bus.req_valid[g] && (m_rv == 0 || bus.rsp_ready)) er[g] = 1'b1;
         chk("req_ready", bus.req_ready, er);
         chk("rsp_valid", bus.rsp_valid, m_rv);
         chk("err_trunc", bus.err_trunc, m_err);
         if (m_rv != 0) begin
            chk("rsp_sum",  bus.rsp_sum,  m_sum);
            chk("rsp_co",   bus.rsp_co,   m_co);
            chk("rsp_id",   bus.rsp_id,   m_id);
            chk("rsp_beat", bus.rsp_beat, m_bt);
            chk("rsp_last", bus.rsp_last, m_last);
         end
         if (er != 0) begin
            cin    = (m_beat == 0) ? int'(bus.req_ci[g]) : m_carry;
            s      = int'(bus.req_a[g]) + int'(bus.req_b[g]) + cin;
            fin    = (bus.req_last[g] || m_beat == MAXB-1) ? 1 : 0;
            if (!bus.req_last[g] && m_beat == MAXB-1) m_err = 1;
            m_sum  = s % 65536;
            m_co   = s / 65536;
            m_carry = m_co;
            m_id   = g;
            m_bt   = m_beat;
            m_last = fin;
            m_rv   = 1;
            if (fin != 0) begin
               m_beat = 0; m_owner = -1; m_ptr = (g + 1) % NREQ;
            end else begin
               m_beat = m_beat + 1; m_owner = g;
            end
         end else if (bus.rsp_ready) m_rv = 0;
      end
   end

   // ---------------- stimulus helpers
   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic clr();
      bus.req_valid = '0; bus.req_last = '0; bus.req_ci = '0;
      bus.req_a = '0; bus.req_b = '0;
   endtask

   task automatic drv(input int i, input logic [15:0] a, input logic [15:0] b,
                      input logic ci, input logic last);
      bus.req_valid[i] = 1'b1;
      bus.req_a[i] = a; bus.req_b[i] = b;
      bus.req_ci[i] = ci; bus.req_last[i] = last;
   endtask

   task automatic chk_rsp(input string nm, input int sum, input int co, input int id,
                          input int bt, input int last);
      chk({nm, "_valid"}, bus.rsp_valid, 1);
      chk({nm, "_sum"},   bus.rsp_sum,   sum);
      chk({nm, "_co"},    bus.rsp_co,    co);
      chk({nm, "_id"},    bus.rsp_id,    id);
      chk({nm, "_beat"},  bus.rsp_beat,  bt);
      chk({nm, "_last"},  bus.rsp_last,  last);
   endtask

   initial begin
      rst_n = 1'b0;
      clr();
      bus.rsp_ready = 1'b1;
      #3;
      chk("init_valid", bus.rsp_valid, 0);
      chk("init_err",   bus.err_trunc, 0);
      step(); step();
      #1 rst_n = 1'b1;
      step();

      // single beat with carry out
      drv(0, 16'hFFFF, 16'h0001, 1'b0, 1'b1);
      #1 chk("t1_ready", bus.req_ready, 4'b0001);
      step(); clr();
      chk_rsp("t1", 0, 1, 0, 0, 1);

      // 32-bit add: carry chains into the second word
      drv(1, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
      step();
      chk_rsp("t2b0", 0, 1, 1, 0, 0);
      drv(1, 16'h0000, 16'h0000, 1'b0, 1'b1);
      step(); clr();
      chk_rsp("t2b1", 1, 0, 1, 1, 1);

      // park pointer at 0, then all four contend with one-beat packets
      drv(3, 16'h0000, 16'h0000, 1'b0, 1'b1);
      step(); clr();
      for (int i = 0; i < NREQ; i++) drv(i, 16'(i), 16'h0010, 1'b0, 1'b1);
      for (int k = 0; k < 5; k++) begin
         #1 chk("t3_grant", bus.req_ready, 4'b0001 << (k % 4));
         step();
         chk("t3_id", bus.rsp_id, k % 4);
      end
      clr();

      // lock: req2 stalls mid-packet while req0 waits
      drv(2, 16'h0001, 16'h0001, 1'b0, 1'b0);
      #1 chk("t4_first", bus.req_ready, 4'b0100);
      step();
      bus.req_valid[2] = 1'b0;
      drv(0, 16'h0002, 16'h0002, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) begin
         #1 chk("t4_locked", bus.req_ready, 4'b0000);
         step();
      end
      drv(2, 16'h0003, 16'h0003, 1'b0, 1'b1);
      #1 chk("t4_owner_last", bus.req_ready, 4'b0100);
      step();
      #1 chk("t4_next", bus.req_ready, 4'b0001);
      step(); clr();

      // backpressure holds the result and blocks new beats
      drv(1, 16'h1234, 16'h0001, 1'b0, 1'b1);
      #1 chk("t5_ready", bus.req_ready, 4'b0010);
      step();
      drv(1, 16'h0100, 16'h0001, 1'b1, 1'b1);
      bus.rsp_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1 chk("t5_blocked", bus.req_ready, 4'b0000);
         chk("t5_hold", bus.rsp_sum, 16'h1235);
         step();
      end
      bus.rsp_ready = 1'b1;
      #1 chk("t5_release", bus.req_ready, 4'b0010);
      step(); clr();
      chk_rsp("t5", 16'h0102, 0, 1, 0, 1);

      // truncation at MAXBEATS, then a fresh packet takes req_ci again
      drv(3, 16'h0001, 16'h0000, 1'b1, 1'b0);
      for (int k = 0; k < 5; k++) begin
         step();
         chk_rsp("t6", (k % 4 == 0) ? 2 : 1, 0, 3, k % 4, (k == 3) ? 1 : 0);
         chk("t6_err", bus.err_trunc, (k >= 3) ? 1 : 0);
      end
      #1 rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", bus.rsp_valid, 0);
      chk("t6_rst_ready", bus.req_ready, 0);
      chk("t6_rst_err",   bus.err_trunc, 0);
      chk("t6_rst_sum",   bus.rsp_sum,   0);
      chk("t6_rst_misc",  {bus.rsp_co, bus.rsp_id, bus.rsp_beat, bus.rsp_last}, 0);
      clr();
      step();
      #1 rst_n = 1'b1;
      step();

      // randomized traffic, model checks every cycle
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            bus.req_valid[i] = ($urandom_range(0, 3) != 0);
            bus.req_last[i]  = ($urandom_range(0, 2) == 0);
            bus.req_ci[i]    = 1'($urandom_range(0, 1));
            bus.req_a[i]     = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            bus.req_b[i]     = ($urandom_range(0, 3) == 0) ? 16'h0001 : 16'($urandom);
         end
         bus.rsp_ready = ($urandom_range(0, 3) != 0);
         rst_n = !(c == 1500);
         step();
      end
      rst_n = 1'b1;
      clr();
      step(); step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
